// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one single-delay-feedback FFT stage: accepts the
// sample stream, steers the delay line and tags delay-line outputs with index/last.
module sdf_stage_ctrl #(
    parameter int DELAY = 4,
    parameter int FRAME = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     shift_en,
    output logic                     zero_in,
    output logic                     bfly_sel,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [$clog2(FRAME)-1:0] tw_idx,
    output logic                     busy
);

    // Handshake: a sample transfers in every cycle where in_valid && in_ready;
    // in_ready never waits on in_valid except to recognise the frame-boundary flush.

    localparam int SW = $clog2(FRAME);
    localparam int DW = $clog2(DELAY);
    localparam int FW = $clog2(DELAY + 1);

    localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);
    localparam logic [FW-1:0] FILL_THR = FW'(DELAY - 1);
    localparam logic [DW-1:0] F_INIT   = DW'(DELAY - 1);
    localparam logic [DW-1:0] F_LAST   = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [SW-1:0]   o_q, o_d;
    logic [DW-1:0]   f_q, f_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [SW-1:0]   tw_idx_q, tw_idx_d;

    logic            flush_cyc;
    logic            accept;
    logic [DW-1:0]   f_cur;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        fill_d   = fill_q;
        o_d      = o_q;
        f_d      = f_q;

        // A RUN cycle at the frame boundary with no new sample already counts
        // as the first flush cycle, so the tail drains without a bubble.
        flush_cyc = (state_q == ST_FLUSH) ||
                    ((state_q == ST_RUN) && (s_q == '0) && !in_valid);
        in_ready  = !flush_cyc;
        accept    = in_valid && in_ready;
        shift_en  = accept || flush_cyc;
        zero_in   = flush_cyc;
        bfly_sel  = accept && s_q[DW];
        f_cur     = (state_q == ST_FLUSH) ? f_q : F_INIT;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    s_d     = SW'(1);
                    fill_d  = FW'(1);
                end
            end
            ST_RUN, ST_FLUSH: begin
                if (accept) begin
                    s_d = s_q + SW'(1);
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + FW'(1);
                    end
                end else if (flush_cyc) begin
                    if (f_cur == F_LAST) begin
                        state_d = ST_IDLE;
                        fill_d  = '0;
                        f_d     = '0;
                    end else begin
                        state_d = ST_FLUSH;
                        f_d     = f_cur - DW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The delay line is full enough once DELAY-1 shifts have happened, so
        // this shift pushes a real sample out of its last tap.
        out_valid_d = shift_en && (fill_q >= FILL_THR);
        out_last_d  = out_valid_d && (o_q == '1);
        tw_idx_d    = o_q;
        if (out_valid_d) begin
            o_d = o_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            fill_q      <= '0;
            o_q         <= '0;
            f_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tw_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            o_q         <= o_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tw_idx_q    <= tw_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tw_idx    = tw_idx_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl: a delay-line model predicts output timing,
// and an index/last scoreboard follows each accepted sample to its output.
module tb_sdf_stage_ctrl;

    localparam int DELAY = 4;
    localparam int FRAME = 64;
    localparam int SW    = $clog2(FRAME);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          zero_in;
    logic          bfly_sel;
    logic          out_valid;
    logic          out_last;
    logic [SW-1:0] tw_idx;
    logic          busy;

    int            checks   = 0;
    int            failures = 0;
    logic [SW:0]   exp_q[$];
    bit            line_q[$];
    int            k;
    bit            in_frame;
    int            flush_left;
    logic          ov_exp;
    int            cyc;
    int            t0;
    int            ov_first;
    int            ov_lastc;
    int            lastc_q[$];

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.DELAY(DELAY), .FRAME(FRAME)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .shift_en (shift_en),
        .zero_in  (zero_in),
        .bfly_sel (bfly_sel),
        .out_valid(out_valid),
        .out_last (out_last),
        .tw_idx   (tw_idx),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_model();
        k          = 0;
        in_frame   = 1'b0;
        flush_left = 0;
        ov_exp     = 1'b0;
        line_q.delete();
        exp_q.delete();
    endtask

    task automatic begin_test();
        t0       = cyc;
        ov_first = -1;
        ov_lastc = -1;
        lastc_q.delete();
    endtask

    // One clock cycle: drive in_valid, predict the control outputs, compare
    // at the falling edge, then advance the delay-line model.
    task automatic step(input bit v);
        logic        exp_flush;
        logic        exp_acc;
        logic        exp_shift;
        logic        exp_bfly;
        logic        ov_next;
        logic [SW:0] item;
        in_valid = v;
        if (flush_left == 0 && in_frame && k == 0 && !v) flush_left = DELAY - 1;
        exp_flush = (flush_left > 0);
        exp_acc   = v && !exp_flush;
        exp_shift = exp_acc || exp_flush;
        exp_bfly  = exp_acc && ((k % (2 * DELAY)) >= DELAY);
        ov_next   = 1'b0;
        @(negedge clk);
        check("in_ready",  32'(in_ready),  32'(!exp_flush));
        check("shift_en",  32'(shift_en),  32'(exp_shift));
        check("zero_in",   32'(zero_in),   32'(exp_flush));
        check("bfly_sel",  32'(bfly_sel),  32'(exp_bfly));
        check("busy",      32'(busy),      32'(in_frame));
        check("out_valid", 32'(out_valid), 32'(ov_exp));
        if (ov_exp) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'(1));
            end else begin
                item = exp_q.pop_front();
                check("sb_last_idx", 32'({out_last, tw_idx}), 32'(item));
            end
        end else begin
            check("out_last_idle", 32'(out_last), 32'(0));
        end
        if (out_valid === 1'b1) begin
            if (ov_first < 0) ov_first = cyc;
            ov_lastc = cyc;
        end
        if (out_last === 1'b1) lastc_q.push_back(cyc);
        if (exp_acc) begin
            exp_q.push_back({(k == FRAME - 1), SW'(k)});
            k        = (k + 1) % FRAME;
            in_frame = 1'b1;
        end
        if (exp_shift) begin
            line_q.push_back(exp_acc);
            if (line_q.size() == DELAY) ov_next = line_q.pop_front();
        end
        if (exp_flush) begin
            flush_left--;
            if (flush_left == 0) begin
                in_frame = 1'b0;
                line_q.delete();
            end
        end
        @(posedge clk);
        #1;
        ov_exp = ov_next;
        cyc++;
    endtask

    task automatic drain();
        repeat (DELAY + 4) step(1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cyc      = 0;
        clear_model();

        // Reset values, including the in_valid pass-through while held in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        check("rst_tw_idx",    32'(tw_idx),    32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_shift_en",  32'(shift_en),  32'(0));
        check("rst_zero_in",   32'(zero_in),   32'(0));
        in_valid = 1'b1;
        #1;
        check("rst_shift_v",   32'(shift_en),  32'(1));
        check("rst_ready_v",   32'(in_ready),  32'(1));
        check("rst_bfly_v",    32'(bfly_sel),  32'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0);
        check("idle_tw_idx", 32'(tw_idx), 32'(0));

        // One contiguous frame.
        begin_test();
        repeat (FRAME) step(1'b1);
        drain();
        check("f1_first_ov", 32'(ov_first - t0), 32'(DELAY));
        check("f1_last_ov",  32'(ov_lastc - t0), 32'(FRAME + DELAY - 1));
        check("f1_last_cnt", 32'(lastc_q.size()), 32'(1));
        if (lastc_q.size() > 0) check("f1_last_cyc", 32'(lastc_q[0] - t0), 32'(FRAME + DELAY - 1));

        // Two back-to-back frames: no flush in between.
        begin_test();
        repeat (2 * FRAME) step(1'b1);
        drain();
        check("f2_last_cnt", 32'(lastc_q.size()), 32'(2));
        if (lastc_q.size() == 2) begin
            check("f2_last0", 32'(lastc_q[0] - t0), 32'(FRAME + DELAY - 1));
            check("f2_last1", 32'(lastc_q[1] - t0), 32'(2 * FRAME + DELAY - 1));
        end

        // Mid-frame stall in cycles 10..12.
        begin_test();
        for (int c = 0; c < FRAME + 3; c++) step(!(c >= 10 && c <= 12));
        drain();
        check("st_first_ov", 32'(ov_first - t0), 32'(DELAY));
        check("st_last_cnt", 32'(lastc_q.size()), 32'(1));
        if (lastc_q.size() > 0) check("st_last_cyc", 32'(lastc_q[0] - t0), 32'(FRAME + DELAY + 2));

        // in_valid raised in the last flush cycle is taken in the next IDLE cycle.
        begin_test();
        repeat (FRAME) step(1'b1);
        repeat (DELAY - 2) step(1'b0);
        repeat (FRAME + 1) step(1'b1);
        drain();
        check("ev_last_cnt", 32'(lastc_q.size()), 32'(2));
        if (lastc_q.size() == 2) begin
            check("ev_last0", 32'(lastc_q[0] - t0), 32'(FRAME + DELAY - 1));
            check("ev_last1", 32'(lastc_q[1] - t0), 32'(2 * FRAME + 2 * DELAY - 2));
        end

        // Random input gaps; any gap landing on a frame boundary starts a flush.
        begin_test();
        repeat (150) step($urandom_range(0, 3) != 0);
        while (k != 0) step(1'b1);
        drain();

        // Reset in cycle 30 of a frame, restart in cycle 35.
        begin_test();
        repeat (30) step(1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check("mr_out_valid", 32'(out_valid), 32'(0));
        check("mr_tw_idx",    32'(tw_idx),    32'(0));
        check("mr_busy",      32'(busy),      32'(0));
        check("mr_in_ready",  32'(in_ready),  32'(1));
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = 1'b1;
        ov_first = -1;
        repeat (4) step(1'b0);
        repeat (FRAME) step(1'b1);
        drain();
        check("mr_first_ov", 32'(ov_first - t0), 32'(35 + DELAY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
